dsp48a1_slice: RTL and testbench
================================

// Module: dsp48a1_slice
// PURPOSE
//  Single-clock DSP slice modelled on the Spartan-6 DSP48A1: 18-bit pre-adder/subtractor,
//  18x18 unsigned multiplier and 48-bit post-adder/subtractor/accumulator, with optional pipeline regs.
//  Sits in datapath arithmetic; cascades via BCIN/BCOUT and PCIN/PCOUT to neighbouring slices.
// PARAMETERS
//  A0REG 0 / A1REG 1      - 1 = register A at stage 0 / stage 1 (0 = pass-through, combinational)
//  B0REG 0 / B1REG 1      - 1 = register B at stage 0 / stage 1 (B1 sits after pre-adder mux)
//  CREG 1, DREG 1         - 1 = register C / D inputs
//  MREG 1, PREG 1         - 1 = register multiplier output / post-adder output
//  CARRYINREG 1           - 1 = register post-adder carry-in
//  CARRYOUTREG 1          - 1 = register CARRYOUT
//  OPMODEREG 1            - 1 = register OPMODE
//  CARRYINSEL "OPMODE5"   - carry-in source: "OPMODE5" = OPMODE[5], "CARRYIN" = CARRYIN port
//  B_INPUT "DIRECT"       - B stage-0 source: "DIRECT" = B port, "CASCADE" = BCIN
// PORTS
//  CLK        in   1   single clock; all regs update on rising edge
//  RSTA,RSTB,RSTC,RSTD,RSTM,RSTP,RSTOPMODE,RSTCARRYIN  in 1 each  per-group reset, synchronous, active-low (0 clears)
//  CEA,CEB,CEC,CED,CEM,CEP,CEOPMODE,CECARRYIN  in 1 each  clock enables, active-high (0 holds)
//  A,B,D      in   18  multiplier/pre-adder operands
//  BCIN       in   18  B cascade input
//  C          in   48  post-adder operand
//  PCIN       in   48  P cascade input
//  CARRYIN    in   1   external carry-in
//  OPMODE     in   8   operation select (see BEHAVIOUR)
//  M          out  36  multiplier result (after MREG)
//  P          out  48  post-adder result (after PREG)
//  PCOUT      out  48  copy of P
//  BCOUT      out  18  B1-stage value (multiplier B operand)
//  CARRYOUT   out  1   post-adder carry/borrow (after CARRYOUTREG)
//  CARRYOUTF  out  1   copy of CARRYOUT
// BEHAVIOUR
//  - Every reg: if RSTx==0 -> 0 at edge (reset wins over CE); else if CEx -> load; else hold.
//    A0/A1 use RSTA/CEA; B0/B1 RSTB/CEB; C RSTC/CEC; D RSTD/CED; M RSTM/CEM; P and CARRYOUT RSTP/CEP.
//    Reg param = 0 -> stage is a wire. All outputs read 0 after reset with PREG/MREG=1.
//  - OPMODE (after OPMODEREG) drives all muxes: [1:0] X, [3:2] Z, [4] pre-add use, [5] cin, [6] pre-sub, [7] post-sub.
//  - Pre-adder: OPMODE[6]=0 -> D+B0, =1 -> D-B0; 18-bit, wraps modulo 2^18.
//  - B1 input = OPMODE[4] ? pre-adder : B0. BCOUT = B1 output.
//  - M = B1 * A1, unsigned 36-bit, then MREG.
//  - X mux: 0 -> 0; 1 -> {12'b0,M}; 2 -> P (feedback); 3 -> {Dreg[11:0], A1, B1}.
//  - Z mux: 0 -> 0; 1 -> PCIN; 2 -> P; 3 -> Creg.
//  - CIN = CARRYINSEL ? OPMODE[5] : CARRYIN, through CARRYINREG (RSTCARRYIN/CECARRYIN).
//  - Post-adder, 49-bit unsigned: OPMODE[7]=0 -> Z+X+CIN; =1 -> Z-(X+CIN). Bits[47:0] -> P, bit48 -> CARRYOUT
//    (borrow shows as 1 on underflow). Result wraps modulo 2^48.
//  - Latency (defaults) from A/B/D/OPMODE change to P: 3 edges (D/OPMODE reg, B1/A1+M, P). C path: 2 edges.
//  - Accumulate (X or Z = P) uses current P each edge; with CEP=0 P holds.
//  - Mid-operation reset of a stage clears only that stage; downstream regs flush over following edges.
//  - Invalid parameter strings: treat CARRYINSEL as "OPMODE5", B_INPUT as "DIRECT".
// TESTING
//  1) D=10,B=2,A=2,OPMODE=0x11 -> after 3 edges M=24, P=24, CARRYOUT=0.
//  2) D=1,B=3,A=2,C=2,OPMODE=0x1D -> P=10; then D=3,B=1,A=1,C=1,OPMODE=0x3D -> P=6.
//  3) C=20,OPMODE=0x2C,CARRYIN=0 -> P=21 (cin from OPMODE[5], port ignored).
//  4) D=10,B=5,A=1,OPMODE=0x51 -> P=5 (pre-subtract); D=A=B=1,OPMODE=0x03 -> P={12'd1,18'd1,18'd1}.
//  5) B=5,A=1,PCIN=20,OPMODE=0xA5 -> P=14; then OPMODE=0x0A with RSTA..RSTM=0 -> P=28, then 56 each edge.
//  6) Reset/CE: RSTP=0 mid-run -> P=0 next edge; CEP=0 -> P holds; B_INPUT="CASCADE" -> BCOUT follows BCIN.

Source files
------------

// File: rtl/dsp48a1_slice_if.sv
// rtl/dsp48a1_slice_if.sv - operand/result bundle for the dsp48a1_slice DSP slice
interface dsp48a1_slice_if;
    logic [17:0] A;
    logic [17:0] B;
    logic [17:0] D;
    logic [17:0] BCIN;
    logic [47:0] C;
    logic [47:0] PCIN;
    logic        CARRYIN;
    logic [7:0]  OPMODE;
    logic [35:0] M;
    logic [47:0] P;
    logic [47:0] PCOUT;
    logic [17:0] BCOUT;
    logic        CARRYOUT;
    logic        CARRYOUTF;

    modport master (
        output A, B, D, BCIN, C, PCIN, CARRYIN, OPMODE,
        input  M, P, PCOUT, BCOUT, CARRYOUT, CARRYOUTF
    );

    modport slave (
        input  A, B, D, BCIN, C, PCIN, CARRYIN, OPMODE,
        output M, P, PCOUT, BCOUT, CARRYOUT, CARRYOUTF
    );
endinterface

// File: rtl/dsp48a1_slice.sv
// rtl/dsp48a1_slice.sv - DSP48A1-style pre-adder, 18x18 multiplier and 48-bit post-adder slice
module dsp48a1_slice #(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic CLK,
    input  logic RSTA,
    input  logic RSTB,
    input  logic RSTC,
    input  logic RSTD,
    input  logic RSTM,
    input  logic RSTP,
    input  logic RSTOPMODE,
    input  logic RSTCARRYIN,
    input  logic CEA,
    input  logic CEB,
    input  logic CEC,
    input  logic CED,
    input  logic CEM,
    input  logic CEP,
    input  logic CEOPMODE,
    input  logic CECARRYIN,
    dsp48a1_slice_if.slave bus
);

    // Anything other than the exact alternate string falls back to the default source.
    localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");
    localparam bit B_CASCADE     = (B_INPUT == "CASCADE");

    logic [7:0]  op_q, opv;
    logic [17:0] a0_q, a0v, a1_q, a1v;
    logic [17:0] b0_src, b0_q, b0v, b1_d, b1_q, b1v;
    logic [17:0] d_q, dv, pre_d;
    logic [47:0] c_q, cv;
    logic [35:0] mul_a, mul_b, prod_d, m_q, mv;
    logic        cin_d, cin_q, cinv;
    logic [47:0] x_d, z_d, pv;
    logic [48:0] post_d;
    logic [47:0] p_q;
    logic        cout_q;

    // Opmode register: selects every mux downstream.
    always_ff @(posedge CLK) begin
        if (!RSTOPMODE)    op_q <= '0;
        else if (CEOPMODE) op_q <= bus.OPMODE;
    end
    assign opv = (OPMODEREG != 0) ? op_q : bus.OPMODE;

    // A stage 0 register.
    always_ff @(posedge CLK) begin
        if (!RSTA)    a0_q <= '0;
        else if (CEA) a0_q <= bus.A;
    end
    assign a0v = (A0REG != 0) ? a0_q : bus.A;

    // A stage 1 register (multiplier A operand).
    always_ff @(posedge CLK) begin
        if (!RSTA)    a1_q <= '0;
        else if (CEA) a1_q <= a0v;
    end
    assign a1v = (A1REG != 0) ? a1_q : a0v;

    assign b0_src = B_CASCADE ? bus.BCIN : bus.B;

    // B stage 0 register.
    always_ff @(posedge CLK) begin
        if (!RSTB)    b0_q <= '0;
        else if (CEB) b0_q <= b0_src;
    end
    assign b0v = (B0REG != 0) ? b0_q : b0_src;

    // D register feeding the pre-adder.
    always_ff @(posedge CLK) begin
        if (!RSTD)    d_q <= '0;
        else if (CED) d_q <= bus.D;
    end
    assign dv = (DREG != 0) ? d_q : bus.D;

    // Pre-adder wraps at 18 bits; B1 takes either its result or B0.
    assign pre_d = opv[6] ? (dv - b0v) : (dv + b0v);
    assign b1_d  = opv[4] ? pre_d : b0v;

    // B stage 1 register (multiplier B operand, also the cascade output).
    always_ff @(posedge CLK) begin
        if (!RSTB)    b1_q <= '0;
        else if (CEB) b1_q <= b1_d;
    end
    assign b1v = (B1REG != 0) ? b1_q : b1_d;

    // With MREG the product register captures on the same edge as B1/A1, so the
    // multiply costs one edge in total and A/B/D reach P in three edges.
    assign mul_b  = {18'b0, (MREG != 0) ? b1_d : b1v};
    assign mul_a  = {18'b0, (MREG != 0) ? a0v  : a1v};
    assign prod_d = mul_b * mul_a;

    // Multiplier output register.
    always_ff @(posedge CLK) begin
        if (!RSTM)    m_q <= '0;
        else if (CEM) m_q <= prod_d;
    end
    assign mv = (MREG != 0) ? m_q : prod_d;

    // C operand register.
    always_ff @(posedge CLK) begin
        if (!RSTC)    c_q <= '0;
        else if (CEC) c_q <= bus.C;
    end
    assign cv = (CREG != 0) ? c_q : bus.C;

    // Registered carry-in taps the opmode bit ahead of OPMODEREG so it lines up
    // with the registered opmode it accompanies.
    assign cin_d = CIN_FROM_PORT ? bus.CARRYIN
                 : ((CARRYINREG != 0) ? bus.OPMODE[5] : opv[5]);

    // Carry-in register.
    always_ff @(posedge CLK) begin
        if (!RSTCARRYIN)    cin_q <= 1'b0;
        else if (CECARRYIN) cin_q <= cin_d;
    end
    assign cinv = (CARRYINREG != 0) ? cin_q : cin_d;

    // X/Z operand selection and 49-bit post-adder; bit 48 is carry or borrow.
    always_comb begin
        x_d = '0;
        z_d = '0;
        case (opv[1:0])
            2'd0:    x_d = '0;
            2'd1:    x_d = {12'b0, mv};
            2'd2:    x_d = pv;
            default: x_d = {dv[11:0], a1v, b1v};
        endcase
        case (opv[3:2])
            2'd0:    z_d = '0;
            2'd1:    z_d = bus.PCIN;
            2'd2:    z_d = pv;
            default: z_d = cv;
        endcase
        if (opv[7]) post_d = {1'b0, z_d} - ({1'b0, x_d} + {48'b0, cinv});
        else        post_d = {1'b0, z_d} + {1'b0, x_d} + {48'b0, cinv};
    end

    // P and CARRYOUT registers share the P reset and enable.
    always_ff @(posedge CLK) begin
        if (!RSTP) begin
            p_q    <= '0;
            cout_q <= 1'b0;
        end else if (CEP) begin
            p_q    <= post_d[47:0];
            cout_q <= post_d[48];
        end
    end

    // Feedback from P only makes sense registered; unregistered P is a plain wire.
    generate
        if (PREG != 0) begin : g_preg
            assign pv = p_q;
        end else begin : g_pwire
            assign pv = post_d[47:0];
        end
    endgenerate

    assign bus.M         = mv;
    assign bus.P         = pv;
    assign bus.PCOUT     = pv;
    assign bus.BCOUT     = b1v;
    assign bus.CARRYOUT  = (CARRYOUTREG != 0) ? cout_q : post_d[48];
    assign bus.CARRYOUTF = bus.CARRYOUT;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// tb/tb_dsp48a1_slice.sv - directed table and sequence bench for dsp48a1_slice
module tb_dsp48a1_slice;

    logic CLK;
    logic RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTOPMODE, RSTCARRYIN;
    logic CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN;

    dsp48a1_slice_if bus ();
    dsp48a1_slice_if bus2 ();

    dsp48a1_slice dut (
        .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
        .RSTP(RSTP), .RSTOPMODE(RSTOPMODE), .RSTCARRYIN(RSTCARRYIN),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
        .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN), .bus(bus)
    );

    dsp48a1_slice #(.CARRYINSEL("CARRYIN"), .B_INPUT("CASCADE")) dut2 (
        .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
        .RSTP(RSTP), .RSTOPMODE(RSTOPMODE), .RSTCARRYIN(RSTCARRYIN),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
        .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN), .bus(bus2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  op;
        logic [17:0] a, b, d;
        logic [47:0] c, pcin;
        logic        cin;
        logic [47:0] exp_p;
        logic [35:0] exp_m;
        logic        exp_co;
        logic [17:0] exp_bc;
    } vec_t;

    vec_t vt[12];
    int checks = 0;
    int errors = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_resets(input logic v);
        RSTA = v; RSTB = v; RSTC = v; RSTD = v; RSTM = v;
        RSTP = v; RSTOPMODE = v; RSTCARRYIN = v;
    endtask

    task automatic drive(input vec_t v);
        bus.OPMODE = v.op; bus.A = v.a; bus.B = v.b; bus.D = v.d;
        bus.C = v.c; bus.PCIN = v.pcin; bus.CARRYIN = v.cin;
    endtask

    initial begin
        //            op     a        b        d       c                  pcin cin  exp_p                exp_m            co   bc
        vt[0]  = '{8'h11, 18'd2,   18'd2,   18'd10, 48'd0,             48'd0,  1'b0, 48'd24,            36'd24,          1'b0, 18'd12};
        vt[1]  = '{8'h1D, 18'd2,   18'd3,   18'd1,  48'd2,             48'd0,  1'b0, 48'd10,            36'd8,           1'b0, 18'd4};
        vt[2]  = '{8'h3D, 18'd1,   18'd1,   18'd3,  48'd1,             48'd0,  1'b0, 48'd6,             36'd4,           1'b0, 18'd4};
        vt[3]  = '{8'h2C, 18'd1,   18'd1,   18'd3,  48'd20,            48'd0,  1'b0, 48'd21,            36'd1,           1'b0, 18'd1};
        vt[4]  = '{8'h51, 18'd1,   18'd5,   18'd10, 48'd0,             48'd0,  1'b0, 48'd5,             36'd5,           1'b0, 18'd5};
        vt[5]  = '{8'h03, 18'd1,   18'd1,   18'd1,  48'd0,             48'd0,  1'b0, 48'h0010_0004_0001, 36'd1,          1'b0, 18'd1};
        vt[6]  = '{8'hA5, 18'd1,   18'd5,   18'd0,  48'd0,             48'd20, 1'b0, 48'd14,            36'd5,           1'b0, 18'd5};
        vt[7]  = '{8'h8D, 18'd1,   18'd5,   18'd0,  48'd3,             48'd0,  1'b0, 48'hFFFF_FFFF_FFFE, 36'd5,          1'b1, 18'd5};
        vt[8]  = '{8'h2C, 18'd0,   18'd0,   18'd0,  48'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 48'd0,             36'd0,           1'b1, 18'd0};
        vt[9]  = '{8'h51, 18'd1,   18'd1,   18'd0,  48'd0,             48'd0,  1'b0, 48'h3FFFF,         36'h3FFFF,       1'b0, 18'h3FFFF};
        vt[10] = '{8'h01, 18'h3FFFF, 18'h3FFFF, 18'd0, 48'd0,          48'd0,  1'b0, 48'hF_FFF8_0001,   36'hF_FFF8_0001, 1'b0, 18'h3FFFF};
        vt[11] = '{8'h0C, 18'd0,   18'd0,   18'd0,  48'd7,             48'd0,  1'b1, 48'd7,             36'd0,           1'b0, 18'd0};

        set_resets(1'b0);
        CEA = 1; CEB = 1; CEC = 1; CED = 1; CEM = 1; CEP = 1; CEOPMODE = 1; CECARRYIN = 1;
        bus.A = 0; bus.B = 0; bus.D = 0; bus.BCIN = 18'h2AAAA; bus.C = 0; bus.PCIN = 0;
        bus.CARRYIN = 0; bus.OPMODE = 0;
        bus2.A = 0; bus2.B = 0; bus2.D = 0; bus2.BCIN = 0; bus2.C = 0; bus2.PCIN = 0;
        bus2.CARRYIN = 0; bus2.OPMODE = 0;
        tick(2);

        // Reset state.
        chk("reset P", bus.P, 48'd0);
        chk("reset M", {12'b0, bus.M}, 48'd0);
        chk("reset PCOUT", bus.PCOUT, 48'd0);
        chk("reset BCOUT", {30'b0, bus.BCOUT}, 48'd0);
        chk("reset CARRYOUT", {47'b0, bus.CARRYOUT}, 48'd0);
        chk("reset CARRYOUTF", {47'b0, bus.CARRYOUTF}, 48'd0);

        // Latency: three edges from inputs to P.
        set_resets(1'b1);
        bus.D = 18'd10; bus.B = 18'd2; bus.A = 18'd2; bus.OPMODE = 8'h11;
        tick(1);
        chk("latency P edge1", bus.P, 48'd0);
        tick(2);
        chk("latency P edge3", bus.P, 48'd24);
        chk("latency M edge3", {12'b0, bus.M}, 48'd24);
        chk("latency CARRYOUT", {47'b0, bus.CARRYOUT}, 48'd0);

        // Accumulate with upstream stages held in reset.
        bus.D = 0; bus.B = 18'd5; bus.A = 18'd1; bus.PCIN = 48'd20; bus.OPMODE = 8'hA5;
        tick(4);
        chk("acc start P", bus.P, 48'd14);
        bus.OPMODE = 8'h0A;
        RSTA = 0; RSTB = 0; RSTC = 0; RSTD = 0; RSTM = 0;
        tick(1);
        chk("acc edge1 P", bus.P, 48'd14);
        chk("acc M cleared", {12'b0, bus.M}, 48'd0);
        tick(1);
        chk("acc edge2 P", bus.P, 48'd28);
        tick(1);
        chk("acc edge3 P", bus.P, 48'd56);
        tick(1);
        chk("acc edge4 P", bus.P, 48'd112);

        // CEP low holds P.
        CEP = 0;
        tick(2);
        chk("CEP hold P", bus.P, 48'd112);
        chk("CEP hold PCOUT", bus.PCOUT, 48'd112);

        // RSTP low clears P on the next edge and wins over CEP.
        RSTP = 0;
        tick(1);
        chk("RSTP clear P", bus.P, 48'd0);
        CEP = 1;
        set_resets(1'b1);

        // Table-driven steady-state vectors.
        for (int i = 0; i < 12; i++) begin
            drive(vt[i]);
            tick(4);
            chk($sformatf("v%0d P", i), bus.P, vt[i].exp_p);
            chk($sformatf("v%0d M", i), {12'b0, bus.M}, {12'b0, vt[i].exp_m});
            chk($sformatf("v%0d CARRYOUT", i), {47'b0, bus.CARRYOUT}, {47'b0, vt[i].exp_co});
            chk($sformatf("v%0d BCOUT", i), {30'b0, bus.BCOUT}, {30'b0, vt[i].exp_bc});
        end

        // Cascade B input and port carry-in on the second slice.
        bus2.OPMODE = 8'h0C; bus2.C = 48'd7; bus2.CARRYIN = 1'b1;
        bus2.BCIN = 18'h01234; bus2.B = 18'h00055; bus2.A = 18'd1;
        tick(4);
        chk("cascade BCOUT", {30'b0, bus2.BCOUT}, 48'h1234);
        chk("cascade M", {12'b0, bus2.M}, 48'h1234);
        chk("port carryin P", bus2.P, 48'd8);
        bus2.BCIN = 18'h00ABC;
        tick(1);
        chk("cascade BCOUT follow", {30'b0, bus2.BCOUT}, 48'hABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
